// File: rtl/refresh_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// refresh_cmd_arbiter
//
// Arbitrates the single DRAM command bus between the refresher and NUM_REQ
// bank-machine command streams, and drives the result into a one-entry
// registered output stage with a valid/ready handshake.
//
// The refresher always wins when it is valid. When the refresher wins with
// ref_cmd_last=0, the bus is locked to the refresher. The lock stays in place
// through gaps in ref_cmd_valid, and it is released when the refresher wins
// with ref_cmd_last=1. Bank streams are served round-robin.
//
// Ports
//   sys_clk, sys_rst_n        rising-edge clock; asynchronous active-low reset
//   ref_cmd_*                 refresher command stream (valid/ready/last + payload)
//   req_valid / req_ready     per-bank-machine handshake, one bit per requester
//   req_payload_*             packed bank payloads; requester i at [i*W +: W]
//   out_valid / out_ready     registered command towards the PHY
//   out_payload_*             registered command payload
//   ref_pending               refresher is valid or holds the bus lock
//   grant                     one-hot source of the out register (MSB = refresher)
//   ref_seq_cnt               number of completed refresh sequences (wraps)
// ---------------------------------------------------------------------------
module refresh_cmd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int A_W     = 17,
  parameter int BA_W    = 3
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    ref_cmd_valid,
  output logic                    ref_cmd_ready,
  input  logic                    ref_cmd_last,
  input  logic [A_W-1:0]          ref_cmd_payload_a,
  input  logic [BA_W-1:0]         ref_cmd_payload_ba,
  input  logic                    ref_cmd_payload_cas,
  input  logic                    ref_cmd_payload_ras,
  input  logic                    ref_cmd_payload_we,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*A_W-1:0]  req_payload_a,
  input  logic [NUM_REQ*BA_W-1:0] req_payload_ba,
  input  logic [NUM_REQ-1:0]      req_payload_cas,
  input  logic [NUM_REQ-1:0]      req_payload_ras,
  input  logic [NUM_REQ-1:0]      req_payload_we,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [A_W-1:0]          out_payload_a,
  output logic [BA_W-1:0]         out_payload_ba,
  output logic                    out_payload_cas,
  output logic                    out_payload_ras,
  output logic                    out_payload_we,
  output logic                    ref_pending,
  output logic [NUM_REQ:0]        grant,
  output logic [15:0]             ref_seq_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REF  = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [PTR_W-1:0]   rr_ptr_r;
  logic [PTR_W-1:0]   cand_s;
  logic [PTR_W-1:0]   bank_idx_s;
  logic               bank_found_s;
  logic               bank_hit_s;
  logic               ref_win_s;
  logic               bank_win_s;
  logic               load_s;

  logic [A_W-1:0]     sel_a_s;
  logic [BA_W-1:0]    sel_ba_s;
  logic               sel_cas_s;
  logic               sel_ras_s;
  logic               sel_we_s;
  logic [NUM_REQ:0]   grant_nxt_s;

  logic               out_valid_r;
  logic [A_W-1:0]     out_a_r;
  logic [BA_W-1:0]    out_ba_r;
  logic               out_cas_r;
  logic               out_ras_r;
  logic               out_we_r;
  logic [NUM_REQ:0]   grant_r;
  logic [15:0]        ref_seq_cnt_r;

  // (base + offset) modulo NUM_REQ; offset never exceeds NUM_REQ-1 here
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                input int offset);
    int sum;
    sum = int'(base) + offset;
    return (sum >= NUM_REQ) ? PTR_W'(sum - NUM_REQ) : PTR_W'(sum);
  endfunction

  // Round-robin search: first valid bank requester at or after rr_ptr, wrapping
  always_comb begin
    bank_found_s = 1'b0;
    bank_idx_s   = '0;
    cand_s       = '0;
    bank_hit_s   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s       = wrap_idx(rr_ptr_r, k);
      bank_hit_s   = ~bank_found_s & req_valid[cand_s];
      bank_idx_s   = bank_hit_s ? cand_s : bank_idx_s;
      bank_found_s = bank_found_s | bank_hit_s;
    end
  end

  // The refresher may win in either state; banks only while the bus is unlocked
  assign ref_win_s  = ref_cmd_valid;
  assign bank_win_s = (state_r == ST_IDLE) & ~ref_cmd_valid & bank_found_s;
  assign load_s     = (~out_valid_r | out_ready) & (ref_win_s | bank_win_s);

  // Readies are held low while reset is asserted, independent of the clock
  assign ref_cmd_ready = sys_rst_n & load_s & ref_win_s;

  // One-hot ready towards the selected bank machine
  always_comb begin
    req_ready = '0;
    if (sys_rst_n && load_s && bank_win_s) begin
      req_ready[bank_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Payload and grant multiplexer for the winning source
  always_comb begin
    sel_a_s     = '0;
    sel_ba_s    = '0;
    sel_cas_s   = 1'b0;
    sel_ras_s   = 1'b0;
    sel_we_s    = 1'b0;
    grant_nxt_s = '0;
    if (ref_win_s) begin
      sel_a_s              = ref_cmd_payload_a;
      sel_ba_s             = ref_cmd_payload_ba;
      sel_cas_s            = ref_cmd_payload_cas;
      sel_ras_s            = ref_cmd_payload_ras;
      sel_we_s             = ref_cmd_payload_we;
      grant_nxt_s[NUM_REQ] = 1'b1;
    end else begin
      sel_a_s                 = req_payload_a[bank_idx_s*A_W +: A_W];
      sel_ba_s                = req_payload_ba[bank_idx_s*BA_W +: BA_W];
      sel_cas_s               = req_payload_cas[bank_idx_s];
      sel_ras_s               = req_payload_ras[bank_idx_s];
      sel_we_s                = req_payload_we[bank_idx_s];
      grant_nxt_s[bank_idx_s] = 1'b1;
    end
  end

  // Lock state: enter on a non-last refresher command, leave on the last one
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (load_s && ref_win_s && !ref_cmd_last) begin
          state_nxt_s = ST_REF;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REF: begin
        if (load_s && ref_win_s && ref_cmd_last) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REF;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Lock state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Round-robin pointer: moves past a served bank, untouched by refresher wins
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rr_ptr_r <= '0;
    end else if (load_s && bank_win_s) begin
      rr_ptr_r <= wrap_idx(bank_idx_s, 1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Completed refresh sequence counter, wraps naturally at 16 bits
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ref_seq_cnt_r <= 16'd0;
    end else if (load_s && ref_win_s && ref_cmd_last) begin
      ref_seq_cnt_r <= ref_seq_cnt_r + 16'd1;
    end else begin
      ref_seq_cnt_r <= ref_seq_cnt_r;
    end
  end

  // Output stage: load the winner, drop valid once drained with nothing new
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out_valid_r <= 1'b0;
      out_a_r     <= '0;
      out_ba_r    <= '0;
      out_cas_r   <= 1'b0;
      out_ras_r   <= 1'b0;
      out_we_r    <= 1'b0;
      grant_r     <= '0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_a_r     <= sel_a_s;
      out_ba_r    <= sel_ba_s;
      out_cas_r   <= sel_cas_s;
      out_ras_r   <= sel_ras_s;
      out_we_r    <= sel_we_s;
      grant_r     <= grant_nxt_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid       = out_valid_r;
  assign out_payload_a   = out_a_r;
  assign out_payload_ba  = out_ba_r;
  assign out_payload_cas = out_cas_r;
  assign out_payload_ras = out_ras_r;
  assign out_payload_we  = out_we_r;
  assign grant           = grant_r;
  assign ref_seq_cnt     = ref_seq_cnt_r;
  assign ref_pending     = ref_cmd_valid | (state_r == ST_REF);

endmodule

// File: tb/tb_refresh_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_refresh_cmd_arbiter
//
// Directed scenarios followed by a randomized run. Every cycle is compared
// against a behavioural model of the arbitration rules: a lock flag, a
// round-robin pointer, and a copy of the output register.
// ---------------------------------------------------------------------------
module tb_refresh_cmd_arbiter;

  localparam int N   = 4;
  localparam int AW  = 17;
  localparam int BAW = 3;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              ref_cmd_valid, ref_cmd_ready, ref_cmd_last;
  logic [AW-1:0]     ref_cmd_payload_a;
  logic [BAW-1:0]    ref_cmd_payload_ba;
  logic              ref_cmd_payload_cas, ref_cmd_payload_ras, ref_cmd_payload_we;
  logic [N-1:0]      req_valid, req_ready;
  logic [N*AW-1:0]   req_payload_a;
  logic [N*BAW-1:0]  req_payload_ba;
  logic [N-1:0]      req_payload_cas, req_payload_ras, req_payload_we;
  logic              out_valid, out_ready;
  logic [AW-1:0]     out_payload_a;
  logic [BAW-1:0]    out_payload_ba;
  logic              out_payload_cas, out_payload_ras, out_payload_we;
  logic              ref_pending;
  logic [N:0]        grant;
  logic [15:0]       ref_seq_cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit             m_locked;
  int             m_ptr;
  logic [15:0]    m_cnt;
  bit             m_ov;
  logic [AW+BAW+2:0] m_pay;
  logic [N:0]     m_grant;

  logic [AW+BAW+2:0] snap;

  always #5 sys_clk = ~sys_clk;

  refresh_cmd_arbiter #(.NUM_REQ(N), .A_W(AW), .BA_W(BAW)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .ref_cmd_valid(ref_cmd_valid), .ref_cmd_ready(ref_cmd_ready),
    .ref_cmd_last(ref_cmd_last), .ref_cmd_payload_a(ref_cmd_payload_a),
    .ref_cmd_payload_ba(ref_cmd_payload_ba), .ref_cmd_payload_cas(ref_cmd_payload_cas),
    .ref_cmd_payload_ras(ref_cmd_payload_ras), .ref_cmd_payload_we(ref_cmd_payload_we),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_payload_a(req_payload_a), .req_payload_ba(req_payload_ba),
    .req_payload_cas(req_payload_cas), .req_payload_ras(req_payload_ras),
    .req_payload_we(req_payload_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_payload_a(out_payload_a), .out_payload_ba(out_payload_ba),
    .out_payload_cas(out_payload_cas), .out_payload_ras(out_payload_ras),
    .out_payload_we(out_payload_we),
    .ref_pending(ref_pending), .grant(grant), .ref_seq_cnt(ref_seq_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_ptr    = 0;
    m_cnt    = 16'd0;
    m_ov     = 1'b0;
    m_pay    = '0;
    m_grant  = '0;
  endtask

  // Winner under the arbitration rules: N = refresher, -1 = nobody
  function automatic int pick();
    if (ref_cmd_valid) return N;
    if (m_locked) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_ref(input bit v, input bit last, input logic [AW-1:0] a,
                         input bit cas, input bit ras, input bit we);
    ref_cmd_valid       = v;
    ref_cmd_last        = last;
    ref_cmd_payload_a   = a;
    ref_cmd_payload_ba  = BAW'($urandom);
    ref_cmd_payload_cas = cas;
    ref_cmd_payload_ras = ras;
    ref_cmd_payload_we  = we;
  endtask

  task automatic rand_bank_payload();
    req_payload_a   = {$urandom, $urandom, $urandom};
    req_payload_ba  = N*BAW'($urandom);
    req_payload_cas = N'($urandom);
    req_payload_ras = N'($urandom);
    req_payload_we  = N'($urandom);
  endtask

  // One clock cycle: check handshake mid-cycle, advance model, check outputs
  task automatic cycle();
    int w;
    bit ld;
    @(negedge sys_clk);
    w  = pick();
    ld = sys_rst_n && (w >= 0) && (!m_ov || out_ready);
    check("ref_cmd_ready", 64'(ref_cmd_ready), 64'(ld && w == N));
    check("req_ready", 64'(req_ready), (ld && w < N) ? (64'd1 << w) : 64'd0);
    check("ref_pending", 64'(ref_pending), 64'(ref_cmd_valid || m_locked));
    @(posedge sys_clk);
    if (sys_rst_n) begin
      if (ld) begin
        m_ov    = 1'b1;
        m_grant = (N+1)'(1) << w;
        if (w == N) begin
          m_pay = {ref_cmd_payload_a, ref_cmd_payload_ba, ref_cmd_payload_cas,
                   ref_cmd_payload_ras, ref_cmd_payload_we};
          if (ref_cmd_last) begin
            m_locked = 1'b0;
            m_cnt    = m_cnt + 16'd1;
          end else begin
            m_locked = 1'b1;
          end
        end else begin
          m_pay = {req_payload_a[w*AW +: AW], req_payload_ba[w*BAW +: BAW],
                   req_payload_cas[w], req_payload_ras[w], req_payload_we[w]};
          m_ptr = (w + 1) % N;
        end
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
    #1;
    check("out_valid", 64'(out_valid), 64'(m_ov));
    check("grant", 64'(grant), 64'(m_grant));
    check("ref_seq_cnt", 64'(ref_seq_cnt), 64'(m_cnt));
    if (m_ov) begin
      check("out_payload", 64'({out_payload_a, out_payload_ba, out_payload_cas,
                                out_payload_ras, out_payload_we}), 64'(m_pay));
    end
  endtask

  initial begin
    logic [AW-1:0] pre_a;
    pre_a = '0;
    pre_a[10] = 1'b1;
    model_reset();

    // Reset with every input valid
    sys_rst_n = 1'b0;
    out_ready = 1'b1;
    req_valid = '1;
    rand_bank_payload();
    set_ref(1'b1, 1'b1, pre_a, 1'b1, 1'b1, 1'b0);
    repeat (3) cycle();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_ref_ready", 64'(ref_cmd_ready), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_seq_cnt", 64'(ref_seq_cnt), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);

    // Release: refresher (single-command sequence) loads on the next edge
    sys_rst_n = 1'b1;
    cycle();
    check("rel_grant", 64'(grant), 64'd1 << N);
    check("rel_seq_cnt", 64'(ref_seq_cnt), 64'd1);

    // Round-robin across all requesters, one command per cycle
    ref_cmd_valid = 1'b0;
    req_valid = '1;
    for (int i = 0; i < 5; i++) begin
      rand_bank_payload();
      cycle();
      check("rr_grant", 64'(grant), 64'd1 << (i % N));
      check("rr_valid", 64'(out_valid), 64'd1);
    end

    // Preemption of a continuously valid req0 by PRE-all then REF
    req_valid = 4'b0001;
    set_ref(1'b1, 1'b0, pre_a, 1'b0, 1'b1, 1'b1);
    cycle();
    check("pre_grant", 64'(grant), 64'd1 << N);
    check("pre_cmd", 64'({out_payload_ras, out_payload_we, out_payload_cas, out_payload_a[10]}), 64'b1101);
    set_ref(1'b1, 1'b1, '0, 1'b1, 1'b1, 1'b0);
    cycle();
    check("ref_grant", 64'(grant), 64'd1 << N);
    check("ref_cmd", 64'({out_payload_ras, out_payload_cas, out_payload_we}), 64'b110);
    check("ref_seq_cnt_2", 64'(ref_seq_cnt), 64'd2);
    ref_cmd_valid = 1'b0;
    cycle();
    check("resume_req0", 64'(grant), 64'd1);

    // Lock held across a 5-cycle gap in the refresh sequence
    req_valid = 4'b0010;
    set_ref(1'b1, 1'b0, pre_a, 1'b0, 1'b1, 1'b1);
    cycle();
    ref_cmd_valid = 1'b0;
    repeat (5) begin
      cycle();
      check("gap_req_ready", 64'(req_ready), 64'd0);
      check("gap_ref_pending", 64'(ref_pending), 64'd1);
    end
    set_ref(1'b1, 1'b1, '0, 1'b1, 1'b1, 1'b0);
    cycle();
    check("gap_ref_grant", 64'(grant), 64'd1 << N);
    ref_cmd_valid = 1'b0;
    cycle();
    check("gap_req1_grant", 64'(grant), 64'd2);

    // Backpressure: output held, nothing accepted, then drain plus load
    req_valid = 4'b0100;
    out_ready = 1'b0;
    snap = {out_payload_a, out_payload_ba, out_payload_cas, out_payload_ras, out_payload_we};
    repeat (10) begin
      cycle();
      check("bp_hold", 64'({out_payload_a, out_payload_ba, out_payload_cas,
                            out_payload_ras, out_payload_we}), 64'(snap));
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    out_ready = 1'b1;
    cycle();
    check("bp_drain_grant", 64'(grant), 64'd4);
    check("bp_drain_valid", 64'(out_valid), 64'd1);

    // Asynchronous reset in the middle of a locked sequence
    req_valid = 4'b0001;
    set_ref(1'b1, 1'b0, pre_a, 1'b0, 1'b1, 1'b1);
    cycle();
    ref_cmd_valid = 1'b0;
    #1 sys_rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_ref_pending", 64'(ref_pending), 64'd0);
    check("arst_req_ready", 64'(req_ready), 64'd0);
    model_reset();
    #1 sys_rst_n = 1'b1;
    cycle();
    check("arst_req0_grant", 64'(grant), 64'd1);

    // Randomized traffic against the model
    repeat (1500) begin
      ref_cmd_valid       = ($urandom_range(0, 4) == 0);
      ref_cmd_last        = ($urandom_range(0, 2) == 0);
      ref_cmd_payload_a   = AW'($urandom);
      ref_cmd_payload_ba  = BAW'($urandom);
      ref_cmd_payload_cas = 1'($urandom);
      ref_cmd_payload_ras = 1'($urandom);
      ref_cmd_payload_we  = 1'($urandom);
      req_valid           = N'($urandom);
      out_ready           = ($urandom_range(0, 3) != 0);
      rand_bank_payload();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
